battle_sequencer: RTL and testbench
===================================

BATTLE_SEQUENCER -- requirements
Module: battle_sequencer

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 16, the maximum number of cycles to wait for calc_done before aborting a turn.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 reset_n  in  1  asynchronous, active-low reset.
REQ-004 go  in  1  start/advance request, level input; the block acts on its rising edge only.
REQ-005 p_move_valid, ai_move_valid  in  1 each  player / AI move selection registered and ready.
REQ-006 p_speed, ai_speed  in  8 each  unsigned speed stats of the active Pokemon.
REQ-007 p_hp, ai_hp  in  8 each  current HP from the datapath; valid one cycle after calc_done.
REQ-008 calc_done  in  1  one-cycle pulse from the damage datapath: damage applied.
REQ-009 load_ai_hp  out  1  datapath loads AI initial HP.
REQ-010 calc_start  out  1  one-cycle pulse launching one damage calculation.
REQ-011 active_trainer  out  1  0 = player attacks, 1 = AI attacks; held from calc_start until calc_done.
REQ-012 target  out  1  0 = player's Pokemon is hit, 1 = AI's; always the inverse of active_trainer while busy.
REQ-013 apply_p_damage, apply_ai_damage  out  1 each  write enables; asserted in the wait state of the matching attack.
REQ-014 busy, victory, loss, timeout_err  out  1 each  status flags.
REQ-015 turn_count  out  8  completed turns, saturating.
REQ-016 state  out  4  current state encoding, for debug LEDs.

Function
REQ-017 States SHALL be: IDLE=0, LOAD_HP=1, WAIT_MOVES=2, ATK1=3, WAIT1=4, CHK1=5, ATK2=6, WAIT2=7, CHK2=8, VICTORY=9, LOSS=10.
REQ-018 go_rise SHALL be go high this cycle and low the previous cycle, using a registered copy of go.
- IDLE: go_rise -> LOAD_HP.
- LOAD_HP: load_ai_hp=1 for exactly one cycle -> WAIT_MOVES.
- WAIT_MOVES: go_rise with p_move_valid and ai_move_valid both high -> ATK1; otherwise hold.
REQ-019 Order SHALL be latched on entry to ATK1: the player attacks first if p_speed >= ai_speed (a tie goes to the player); otherwise the AI attacks first.
REQ-020 ATK1 and ATK2 SHALL assert calc_start for exactly one cycle and then move to WAIT1 or WAIT2 respectively.
REQ-021 WAITn SHALL hold active_trainer, target and the matching apply_* signal until calc_done, then go to CHKn the following cycle.
REQ-022 CHK1 SHALL test the HP of the first attack's target:
- if 0: player attacked -> VICTORY; AI attacked -> LOSS;
- else -> ATK2, with the second attacker being the other trainer.
REQ-023 CHK2 SHALL apply the same HP test to the second target.
- If that HP is nonzero, turn_count increments (saturating at 255) and the state goes to WAIT_MOVES.
REQ-024 Latency from go_rise in WAIT_MOVES to calc_start SHALL be 1 cycle; from calc_done to the next calc_start SHALL be 2 cycles.
REQ-025 A per-wait counter SHALL reset on entry to WAITn; if TIMEOUT cycles elapse without calc_done:
- timeout_err is set (sticky until reset);
- all apply_* outputs drop;
- the state goes to IDLE.
REQ-026 calc_done outside WAITn SHALL be ignored.
REQ-027 go_rise outside IDLE and WAIT_MOVES SHALL be ignored.
REQ-028 VICTORY and LOSS SHALL be terminal, with victory or loss held high; only reset_n exits them.
REQ-029 busy SHALL be high in every state except IDLE, WAIT_MOVES, VICTORY and LOSS.
REQ-030 Outputs SHALL be Moore, decoded from state only, except for the latched order bit; unassigned outputs are 0.

Reset
REQ-031 On reset_n low, asynchronously:
- state=IDLE, turn_count=0, order bit=0, timeout counter=0, go history=0, timeout_err=0;
- all control and status outputs 0.
REQ-032 Reset asserted mid-turn, including during WAITn, SHALL abort the turn with no further calc_start or apply_* output.

Verification
REQ-033 Player faster: p_speed=50, ai_speed=30, ai_hp=0 after first calc_done -> one calc_start with active_trainer=0, apply_ai_damage=1, then victory=1 and no second calc_start.
REQ-034 AI faster: p_speed=10, ai_speed=20, both HP nonzero -> calc_start with active_trainer=1, then calc_start with active_trainer=0, then turn_count=1 and state=WAIT_MOVES.
REQ-035 Speed tie at 40/40 -> player attacks first; if AI then drives p_hp to 0 on the second attack -> loss=1.
REQ-036 go held high for 10 cycles in WAIT_MOVES -> exactly one turn starts; a second turn needs go low then high.
REQ-037 calc_done withheld in WAIT1 for 16 cycles -> timeout_err=1, state=IDLE, apply_* low.
REQ-038 reset_n pulsed low during WAIT2 -> all outputs 0 immediately; turn_count=0 after release.

Source files
------------

// File: rtl/battle_sequencer.sv
// -----------------------------------------------------------------------------
// battle_sequencer
//
// Turn controller for a two-trainer battle. A turn is started from WAIT_MOVES
// by a rising edge on go once both move selections are ready. The faster
// trainer attacks first (a speed tie goes to the player). Each attack is one
// calc_start pulse to the damage datapath, followed by a wait for calc_done and
// a check of the target's HP one cycle later. A zero HP ends the battle
// (VICTORY or LOSS, both terminal until reset). A wait that outlasts TIMEOUT
// cycles aborts to IDLE and sets the sticky timeout_err flag.
//
// Ports
//   clk, reset_n            clock, asynchronous active-low reset
//   go                      start/advance request, acted on at its rising edge
//   p_move_valid,
//   ai_move_valid           both trainers have chosen a move
//   p_speed, ai_speed       speed stats used to pick the attack order
//   p_hp, ai_hp             HP from the datapath, valid the cycle after calc_done
//   calc_done               datapath finished applying damage (1-cycle pulse)
//   load_ai_hp              datapath loads AI initial HP
//   calc_start              launches one damage calculation (1-cycle pulse)
//   active_trainer          0 = player attacks, 1 = AI attacks
//   target                  0 = player's Pokemon is hit, 1 = AI's
//   apply_p_damage,
//   apply_ai_damage         damage write enables during the wait of an attack
//   busy, victory, loss,
//   timeout_err             status flags
//   turn_count              completed turns, saturating at 255
//   state                   current state encoding (debug)
//
// Handshake: calc_start is a single-cycle request; the datapath answers with a
// single-cycle calc_done, which is only honoured while the FSM is waiting for
// it. go is a level that is edge-detected here; only its rising edge counts.
// -----------------------------------------------------------------------------
module battle_sequencer #(
  parameter int TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       go,
  input  logic       p_move_valid,
  input  logic       ai_move_valid,
  input  logic [7:0] p_speed,
  input  logic [7:0] ai_speed,
  input  logic [7:0] p_hp,
  input  logic [7:0] ai_hp,
  input  logic       calc_done,
  output logic       load_ai_hp,
  output logic       calc_start,
  output logic       active_trainer,
  output logic       target,
  output logic       apply_p_damage,
  output logic       apply_ai_damage,
  output logic       busy,
  output logic       victory,
  output logic       loss,
  output logic       timeout_err,
  output logic [7:0] turn_count,
  output logic [3:0] state
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [3:0] {
    S_IDLE       = 4'd0,
    S_LOAD_HP    = 4'd1,
    S_WAIT_MOVES = 4'd2,
    S_ATK1       = 4'd3,
    S_WAIT1      = 4'd4,
    S_CHK1       = 4'd5,
    S_ATK2       = 4'd6,
    S_WAIT2      = 4'd7,
    S_CHK2       = 4'd8,
    S_VICTORY    = 4'd9,
    S_LOSS       = 4'd10
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic          r_go;
  logic          r_ai_first;     // 1 = AI attacks first this turn
  logic [CW-1:0] r_to_cnt;
  logic          r_timeout_err;
  logic [7:0]    r_turn_count;

  logic w_go_rise;
  logic w_phase2;
  logic w_attacker;
  logic w_target_dead;
  logic w_in_wait;
  logic w_to_expire;

  assign w_go_rise = go & ~r_go;

  // The second attack of a turn is always made by the other trainer, so the
  // current attacker is the latched order bit flipped during the second half.
  assign w_phase2   = (r_state == S_ATK2) || (r_state == S_WAIT2) || (r_state == S_CHK2);
  assign w_attacker = r_ai_first ^ w_phase2;

  // Target of the current attack is the trainer that is not attacking.
  assign w_target_dead = w_attacker ? (p_hp == 8'd0) : (ai_hp == 8'd0);

  assign w_in_wait   = (r_state == S_WAIT1) || (r_state == S_WAIT2);
  assign w_to_expire = (r_to_cnt == CW'(TIMEOUT - 1));

  assign state       = r_state;
  assign timeout_err = r_timeout_err;
  assign turn_count  = r_turn_count;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state and Moore output decode
  always_comb begin
    w_next          = r_state;
    load_ai_hp      = 1'b0;
    calc_start      = 1'b0;
    active_trainer  = 1'b0;
    target          = 1'b0;
    apply_p_damage  = 1'b0;
    apply_ai_damage = 1'b0;
    busy            = 1'b0;
    victory         = 1'b0;
    loss            = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (w_go_rise) w_next = S_LOAD_HP;
      end
      S_LOAD_HP: begin
        busy       = 1'b1;
        load_ai_hp = 1'b1;
        w_next     = S_WAIT_MOVES;
      end
      S_WAIT_MOVES: begin
        if (w_go_rise && p_move_valid && ai_move_valid) w_next = S_ATK1;
      end
      S_ATK1, S_ATK2: begin
        busy           = 1'b1;
        calc_start     = 1'b1;
        active_trainer = w_attacker;
        target         = ~w_attacker;
        w_next         = (r_state == S_ATK1) ? S_WAIT1 : S_WAIT2;
      end
      S_WAIT1, S_WAIT2: begin
        busy            = 1'b1;
        active_trainer  = w_attacker;
        target          = ~w_attacker;
        apply_p_damage  = w_attacker;
        apply_ai_damage = ~w_attacker;
        // A done arriving in the last allowed cycle still wins over the abort.
        if (calc_done) begin
          w_next = (r_state == S_WAIT1) ? S_CHK1 : S_CHK2;
        end else if (w_to_expire) begin
          w_next = S_IDLE;
        end
      end
      S_CHK1, S_CHK2: begin
        busy           = 1'b1;
        active_trainer = w_attacker;
        target         = ~w_attacker;
        if (w_target_dead) begin
          w_next = w_attacker ? S_LOSS : S_VICTORY;
        end else begin
          w_next = (r_state == S_CHK1) ? S_ATK2 : S_WAIT_MOVES;
        end
      end
      S_VICTORY: begin
        victory = 1'b1;
      end
      S_LOSS: begin
        loss = 1'b1;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // Datapath registers: go history, attack order, wait timer, status
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_go          <= 1'b0;
      r_ai_first    <= 1'b0;
      r_to_cnt      <= '0;
      r_timeout_err <= 1'b0;
      r_turn_count  <= 8'd0;
    end else begin
      r_go <= go;

      if (r_state == S_WAIT_MOVES && w_next == S_ATK1) begin
        r_ai_first <= (ai_speed > p_speed);
      end

      // Timer is cleared in the ATK state so it reads 0 on the first wait cycle.
      if (w_in_wait) begin
        r_to_cnt <= r_to_cnt + CW'(1);
      end else begin
        r_to_cnt <= '0;
      end

      if (w_in_wait && !calc_done && w_to_expire) begin
        r_timeout_err <= 1'b1;
      end

      if (r_state == S_CHK2 && !w_target_dead && r_turn_count != 8'd255) begin
        r_turn_count <= r_turn_count + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_battle_sequencer.sv
// -----------------------------------------------------------------------------
// tb_battle_sequencer
//
// Drives the sequencer through directed and randomized battle turns. The bench
// plays the damage datapath: it answers each calc_start with a calc_done after
// a chosen delay and presents the post-attack HP values. Expected outcomes come
// from a turn-level model of the battle rules (who is faster, whose HP hits 0).
// -----------------------------------------------------------------------------
module tb_battle_sequencer;

  localparam int TO = 16;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       go;
  logic       p_move_valid;
  logic       ai_move_valid;
  logic [7:0] p_speed;
  logic [7:0] ai_speed;
  logic [7:0] p_hp;
  logic [7:0] ai_hp;
  logic       calc_done;
  logic       load_ai_hp;
  logic       calc_start;
  logic       active_trainer;
  logic       target;
  logic       apply_p_damage;
  logic       apply_ai_damage;
  logic       busy;
  logic       victory;
  logic       loss;
  logic       timeout_err;
  logic [7:0] turn_count;
  logic [3:0] state;

  int n_cmp  = 0;
  int n_fail = 0;

  // Observations of the last played turn
  int   obs_starts;
  logic obs_att      [4];
  int   obs_start_cyc[4];
  int   obs_done_cyc [4];
  logic obs_apply_p  [4];
  logic obs_apply_ai [4];
  int   obs_wait_len [4];

  // Model results
  int   exp_starts;
  logic exp_first;
  int   exp_end;      // 0 = battle continues, 1 = victory, 2 = loss
  int   exp_turns;

  battle_sequencer #(.TIMEOUT(TO)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .go              (go),
    .p_move_valid    (p_move_valid),
    .ai_move_valid   (ai_move_valid),
    .p_speed         (p_speed),
    .ai_speed        (ai_speed),
    .p_hp            (p_hp),
    .ai_hp           (ai_hp),
    .calc_done       (calc_done),
    .load_ai_hp      (load_ai_hp),
    .calc_start      (calc_start),
    .active_trainer  (active_trainer),
    .target          (target),
    .apply_p_damage  (apply_p_damage),
    .apply_ai_damage (apply_ai_damage),
    .busy            (busy),
    .victory         (victory),
    .loss            (loss),
    .timeout_err     (timeout_err),
    .turn_count      (turn_count),
    .state           (state)
  );

  // ---------------------------------------------------------------- clock/reset
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, need finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------------------------------------------------------- model
  // Battle rules at turn level: faster trainer (tie -> player) hits first; a
  // target reaching 0 HP ends the battle in favour of whoever hit it.
  task automatic model_turn(input logic [7:0] ps, input logic [7:0] as,
                            input logic [7:0] p1, input logic [7:0] a1,
                            input logic [7:0] p2, input logic [7:0] a2);
    logic second;
    exp_first = (as > ps);
    if ((exp_first ? p1 : a1) == 8'd0) begin
      exp_starts = 1;
      exp_end    = exp_first ? 2 : 1;
    end else begin
      second     = ~exp_first;
      exp_starts = 2;
      if ((second ? p2 : a2) == 8'd0) exp_end = second ? 2 : 1;
      else                             exp_end = 0;
    end
  endtask

  // ---------------------------------------------------------------- drivers
  task automatic start_game();
    reset_n = 1'b0; go = 1'b0; calc_done = 1'b0;
    p_move_valid = 1'b0; ai_move_valid = 1'b0;
    p_hp = 8'd99; ai_hp = 8'd99;
    tick();
    reset_n = 1'b1;
    tick();
    go = 1'b1;
    tick();
    go = 1'b0;
    tick();
    exp_turns = 0;
  endtask

  // Plays one turn from WAIT_MOVES. d1/d2 are wait cycles before calc_done
  // (255 = never). go stays high for go_hold cycles after it is raised.
  task automatic play_turn(input logic [7:0] ps, input logic [7:0] as,
                           input logic [7:0] p1, input logic [7:0] a1,
                           input logic [7:0] p2, input logic [7:0] a2,
                           input int d1, input int d2, input int go_hold);
    int cyc, wcnt, idx;
    for (int i = 0; i < 4; i++) begin
      obs_att[i] = 1'b0; obs_start_cyc[i] = -1; obs_done_cyc[i] = -1;
      obs_apply_p[i] = 1'b0; obs_apply_ai[i] = 1'b0; obs_wait_len[i] = 0;
    end
    obs_starts = 0;
    p_speed = ps; ai_speed = as;
    p_move_valid = 1'b1; ai_move_valid = 1'b1;
    go = 1'b0; calc_done = 1'b0;
    tick();
    go = 1'b1;
    cyc = 0; wcnt = 0;
    for (int k = 0; k < 200; k++) begin
      tick();
      cyc++;
      calc_done = 1'b0;
      if (cyc >= go_hold) go = 1'b0;
      if (calc_start) begin
        if (obs_starts < 4) begin
          obs_att[obs_starts] = active_trainer;
          obs_start_cyc[obs_starts] = cyc;
        end
        obs_starts++;
        wcnt = 0;
      end
      if ((apply_p_damage || apply_ai_damage) && obs_starts > 0 && obs_starts <= 4) begin
        idx = obs_starts - 1;
        obs_apply_p[idx]  = obs_apply_p[idx] | apply_p_damage;
        obs_apply_ai[idx] = obs_apply_ai[idx] | apply_ai_damage;
        obs_wait_len[idx]++;
        if (wcnt == ((idx == 0) ? d1 : d2)) begin
          calc_done = 1'b1;
          obs_done_cyc[idx] = cyc;
          if (idx == 0) begin p_hp = p1; ai_hp = a1; end
          else          begin p_hp = p2; ai_hp = a2; end
        end
        wcnt++;
      end
      if (obs_starts > 0 && !busy) break;
      if (obs_starts == 0 && cyc >= 4) break;
    end
  endtask

  // ---------------------------------------------------------------- tests
  task automatic test_reset();
    reset_n = 1'b0; go = 1'b0; calc_done = 1'b0;
    p_move_valid = 1'b0; ai_move_valid = 1'b0;
    p_speed = 8'd0; ai_speed = 8'd0; p_hp = 8'd99; ai_hp = 8'd99;
    tick(); tick();
    n_cmp++;
    if ({load_ai_hp, calc_start, active_trainer, target, apply_p_damage, apply_ai_damage,
         busy, victory, loss, timeout_err, turn_count, state} !== 22'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got busy=%b state=%0d turn=%0d, need all zero", busy, state, turn_count);
    end
    reset_n = 1'b1;
    tick(); tick();
    n_cmp++;
    if (state !== 4'd0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle_hold: got state=%0d busy=%b, need state=0 busy=0", state, busy);
    end
  endtask

  task automatic test_load();
    go = 1'b1;
    tick();
    n_cmp++;
    if (load_ai_hp !== 1'b1 || state !== 4'd1 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL load_enter: got load=%b state=%0d busy=%b, need 1/1/1", load_ai_hp, state, busy);
    end
    tick();
    n_cmp++;
    if (load_ai_hp !== 1'b0 || state !== 4'd2 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL load_one_cycle: got load=%b state=%0d busy=%b, need 0/2/0", load_ai_hp, state, busy);
    end
    go = 1'b0;
    tick();
  endtask

  task automatic test_moves_gate();
    int starts;
    starts = 0;
    start_game();
    p_move_valid = 1'b1; ai_move_valid = 1'b0;
    go = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (calc_start) starts++;
    end
    go = 1'b0;
    calc_done = 1'b1;          // stray done outside a wait
    tick();
    calc_done = 1'b0;
    tick();
    n_cmp++;
    if (starts != 0 || state !== 4'd2) begin
      n_fail++;
      $display("FAIL moves_gate: got starts=%0d state=%0d, need 0 and 2", starts, state);
    end
  endtask

  task automatic test_player_faster();
    int extra;
    extra = 0;
    start_game();
    play_turn(8'd50, 8'd30, 8'd80, 8'd0, 8'd80, 8'd80, 2, 2, 1);
    n_cmp++;
    if (obs_starts != 1 || obs_att[0] !== 1'b0 || obs_apply_ai[0] !== 1'b1 || obs_apply_p[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL player_first: got starts=%0d att=%b apply_ai=%b apply_p=%b, need 1/0/1/0",
               obs_starts, obs_att[0], obs_apply_ai[0], obs_apply_p[0]);
    end
    n_cmp++;
    if (victory !== 1'b1 || loss !== 1'b0 || state !== 4'd9) begin
      n_fail++;
      $display("FAIL player_victory: got victory=%b loss=%b state=%0d, need 1/0/9", victory, loss, state);
    end
    // Terminal: go edges and stray dones must not leave VICTORY.
    go = 1'b0; tick();
    go = 1'b1; calc_done = 1'b1; tick();
    calc_done = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (calc_start) extra++;
      tick();
    end
    go = 1'b0;
    n_cmp++;
    if (extra != 0 || victory !== 1'b1 || state !== 4'd9 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL victory_terminal: got starts=%0d victory=%b state=%0d, need 0/1/9", extra, victory, state);
    end
  endtask

  task automatic test_ai_faster();
    start_game();
    play_turn(8'd10, 8'd20, 8'd60, 8'd70, 8'd50, 8'd40, 1, 3, 1);
    n_cmp++;
    if (obs_starts != 2 || obs_att[0] !== 1'b1 || obs_att[1] !== 1'b0) begin
      n_fail++;
      $display("FAIL ai_first_order: got starts=%0d att0=%b att1=%b, need 2/1/0", obs_starts, obs_att[0], obs_att[1]);
    end
    n_cmp++;
    if (obs_apply_p[0] !== 1'b1 || obs_apply_ai[0] !== 1'b0 || obs_apply_ai[1] !== 1'b1 || obs_apply_p[1] !== 1'b0) begin
      n_fail++;
      $display("FAIL ai_first_apply: got p0=%b ai0=%b p1=%b ai1=%b, need 1/0/0/1",
               obs_apply_p[0], obs_apply_ai[0], obs_apply_p[1], obs_apply_ai[1]);
    end
    n_cmp++;
    if (obs_start_cyc[0] != 1 || obs_start_cyc[1] != obs_done_cyc[0] + 2) begin
      n_fail++;
      $display("FAIL latency: got start0=%0d start1=%0d done0=%0d, need 1 and done0+2",
               obs_start_cyc[0], obs_start_cyc[1], obs_done_cyc[0]);
    end
    n_cmp++;
    if (turn_count !== 8'd1 || state !== 4'd2) begin
      n_fail++;
      $display("FAIL ai_first_turn_end: got turn=%0d state=%0d, need 1 and 2", turn_count, state);
    end
  endtask

  task automatic test_tie_loss();
    start_game();
    play_turn(8'd40, 8'd40, 8'd30, 8'd20, 8'd0, 8'd20, 0, 4, 1);
    n_cmp++;
    if (obs_starts != 2 || obs_att[0] !== 1'b0 || obs_att[1] !== 1'b1) begin
      n_fail++;
      $display("FAIL tie_order: got starts=%0d att0=%b att1=%b, need 2/0/1", obs_starts, obs_att[0], obs_att[1]);
    end
    n_cmp++;
    if (loss !== 1'b1 || victory !== 1'b0 || state !== 4'd10 || turn_count !== 8'd0) begin
      n_fail++;
      $display("FAIL tie_loss: got loss=%b victory=%b state=%0d turn=%0d, need 1/0/10/0",
               loss, victory, state, turn_count);
    end
  endtask

  task automatic test_go_held();
    int extra;
    extra = 0;
    start_game();
    play_turn(8'd90, 8'd10, 8'd50, 8'd50, 8'd50, 8'd50, 0, 0, 10);
    for (int k = 0; k < 6; k++) begin
      tick();
      if (calc_start) extra++;
    end
    go = 1'b0;
    n_cmp++;
    if (obs_starts != 2 || extra != 0 || turn_count !== 8'd1 || state !== 4'd2) begin
      n_fail++;
      $display("FAIL go_held_single: got starts=%0d extra=%0d turn=%0d state=%0d, need 2/0/1/2",
               obs_starts, extra, turn_count, state);
    end
    play_turn(8'd90, 8'd10, 8'd50, 8'd50, 8'd50, 8'd50, 0, 0, 1);
    n_cmp++;
    if (obs_starts != 2 || turn_count !== 8'd2) begin
      n_fail++;
      $display("FAIL go_second_turn: got starts=%0d turn=%0d, need 2 and 2", obs_starts, turn_count);
    end
  endtask

  task automatic test_timeout();
    start_game();
    play_turn(8'd50, 8'd30, 8'd50, 8'd50, 8'd50, 8'd50, 255, 255, 1);
    n_cmp++;
    if (obs_starts != 1 || obs_wait_len[0] != TO) begin
      n_fail++;
      $display("FAIL timeout_len: got starts=%0d wait=%0d, need 1 and %0d", obs_starts, obs_wait_len[0], TO);
    end
    n_cmp++;
    if (timeout_err !== 1'b1 || state !== 4'd0 || apply_p_damage !== 1'b0 || apply_ai_damage !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_abort: got err=%b state=%0d ap=%b aa=%b, need 1/0/0/0",
               timeout_err, state, apply_p_damage, apply_ai_damage);
    end
    go = 1'b1; tick(); go = 1'b0; tick();
    n_cmp++;
    if (timeout_err !== 1'b1 || state !== 4'd2) begin
      n_fail++;
      $display("FAIL timeout_sticky: got err=%b state=%0d, need 1 and 2", timeout_err, state);
    end
    // Done on the last allowed wait cycle still completes the attack.
    play_turn(8'd50, 8'd30, 8'd50, 8'd50, 8'd50, 8'd50, TO - 1, 0, 1);
    n_cmp++;
    if (obs_starts != 2 || state !== 4'd2 || turn_count !== 8'd1) begin
      n_fail++;
      $display("FAIL timeout_edge_done: got starts=%0d state=%0d turn=%0d, need 2/2/1", obs_starts, state, turn_count);
    end
  endtask

  task automatic test_reset_wait2();
    int n_st, bad;
    n_st = 0; bad = 0;
    start_game();
    play_turn(8'd10, 8'd20, 8'd50, 8'd50, 8'd50, 8'd50, 0, 0, 1);
    p_speed = 8'd10; ai_speed = 8'd20;
    go = 1'b0; tick();
    go = 1'b1;
    for (int k = 0; k < 40; k++) begin
      tick();
      go = 1'b0;
      calc_done = 1'b0;
      if (calc_start) n_st++;
      if ((apply_p_damage || apply_ai_damage) && n_st == 2) break;
      if ((apply_p_damage || apply_ai_damage) && n_st == 1) calc_done = 1'b1;
    end
    n_cmp++;
    if (n_st != 2 || apply_ai_damage !== 1'b1 || turn_count !== 8'd1) begin
      n_fail++;
      $display("FAIL reset_setup_wait2: got starts=%0d apply_ai=%b turn=%0d, need 2/1/1", n_st, apply_ai_damage, turn_count);
    end
    #2 reset_n = 1'b0;
    #1;
    n_cmp++;
    if ({load_ai_hp, calc_start, active_trainer, target, apply_p_damage, apply_ai_damage,
         busy, victory, loss, timeout_err, turn_count, state} !== 22'd0) begin
      n_fail++;
      $display("FAIL reset_async_wait2: got apply_ai=%b busy=%b state=%0d turn=%0d, need all zero",
               apply_ai_damage, busy, state, turn_count);
    end
    calc_done = 1'b1;
    tick();
    calc_done = 1'b0;
    reset_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (calc_start || apply_p_damage || apply_ai_damage) bad++;
    end
    n_cmp++;
    if (bad != 0 || turn_count !== 8'd0 || state !== 4'd0) begin
      n_fail++;
      $display("FAIL reset_release: got activity=%0d turn=%0d state=%0d, need 0/0/0", bad, turn_count, state);
    end
  endtask

  task automatic test_random();
    logic [7:0] ps, as, p1, a1, p2, a2;
    int d1, d2;
    start_game();
    for (int t = 0; t < 30; t++) begin
      ps = 8'($urandom_range(0, 255));
      as = ($urandom_range(0, 3) == 0) ? ps : 8'($urandom_range(0, 255));
      p1 = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
      a1 = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
      p2 = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
      a2 = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
      d1 = $urandom_range(0, TO - 1);
      d2 = $urandom_range(0, TO - 1);
      model_turn(ps, as, p1, a1, p2, a2);
      if (exp_end == 0) exp_turns++;
      play_turn(ps, as, p1, a1, p2, a2, d1, d2, $urandom_range(1, 12));
      n_cmp++;
      if (obs_starts != exp_starts || obs_att[0] !== exp_first ||
          (exp_starts == 2 && obs_att[1] !== ~exp_first)) begin
        n_fail++;
        $display("FAIL rand_order t=%0d: got starts=%0d att0=%b att1=%b, need starts=%0d first=%b",
                 t, obs_starts, obs_att[0], obs_att[1], exp_starts, exp_first);
      end
      n_cmp++;
      if (obs_apply_ai[0] !== ~exp_first || obs_apply_p[0] !== exp_first || obs_start_cyc[0] != 1 ||
          (exp_starts == 2 && obs_start_cyc[1] != obs_done_cyc[0] + 2)) begin
        n_fail++;
        $display("FAIL rand_timing t=%0d: got ap=%b aa=%b s0=%0d s1=%0d d0=%0d, need first=%b s0=1 s1=d0+2",
                 t, obs_apply_p[0], obs_apply_ai[0], obs_start_cyc[0], obs_start_cyc[1], obs_done_cyc[0], exp_first);
      end
      n_cmp++;
      if (victory !== (exp_end == 1) || loss !== (exp_end == 2) || turn_count !== 8'(exp_turns) ||
          state !== ((exp_end == 0) ? 4'd2 : (exp_end == 1) ? 4'd9 : 4'd10)) begin
        n_fail++;
        $display("FAIL rand_result t=%0d: got v=%b l=%b state=%0d turn=%0d, need end=%0d turn=%0d",
                 t, victory, loss, state, turn_count, exp_end, exp_turns);
      end
      if (exp_end != 0) start_game();
    end
  endtask

  task automatic test_saturate();
    start_game();
    for (int t = 0; t < 257; t++) begin
      play_turn(8'd5, 8'd6, 8'd9, 8'd9, 8'd9, 8'd9, 0, 0, 1);
      if (t == 254) begin
        n_cmp++;
        if (turn_count !== 8'd255) begin
          n_fail++;
          $display("FAIL turn_reach_255: got %0d, need 255", turn_count);
        end
      end
    end
    n_cmp++;
    if (turn_count !== 8'd255 || state !== 4'd2) begin
      n_fail++;
      $display("FAIL turn_saturate: got turn=%0d state=%0d, need 255 and 2", turn_count, state);
    end
  endtask

  // ---------------------------------------------------------------- sequence
  initial begin
    test_reset();
    test_load();
    test_moves_gate();
    test_player_faster();
    test_ai_faster();
    test_tie_loss();
    test_go_held();
    test_timeout();
    test_reset_wait2();
    test_random();
    test_saturate();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
